// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decodes the format of a raw RV32 instruction word,
// builds its sign-extended immediate and extracts rd. Results are queued
// in a 2-entry in-order FIFO so the consumer can stall without bubbles.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   flush            synchronous discard of all buffered entries
//   in_valid/in_ready/in_inst/in_tag                  upstream handshake + payload
//   out_valid/out_ready                               downstream handshake
//   out_imm/out_fmt/out_rd/out_use_rd/out_illegal/out_tag  head entry fields
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [4:0]       out_rd,
    output logic             out_use_rd,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned DEPTH = 2;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // Only RV32 and RV64 immediate widths are meaningful.
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    logic [6:0]      opcode;
    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rd;
    logic            dec_use_rd;
    logic            dec_illegal;

    assign opcode = in_inst[6:0];

    // Format classification and immediate unscrambling (32-bit, sign already in bit 31).
    always_comb begin
        dec_fmt    = FMT_ILL;
        dec_imm32  = '0;
        dec_use_rd = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_fmt    = FMT_R;
                dec_use_rd = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt    = FMT_I;
                dec_imm32  = {{20{in_inst[31]}}, in_inst[31:20]};
                dec_use_rd = 1'b1;
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt    = FMT_U;
                dec_imm32  = {in_inst[31:12], 12'b0};
                dec_use_rd = 1'b1;
            end
            7'b1101111: begin
                dec_fmt    = FMT_J;
                dec_imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
                dec_use_rd = 1'b1;
            end
            default: begin
                dec_fmt = FMT_ILL;
            end
        endcase
    end

    assign dec_imm     = XLEN'($signed(dec_imm32));
    assign dec_rd      = dec_use_rd ? in_inst[11:7] : 5'd0;
    assign dec_illegal = (dec_fmt == FMT_ILL);

    // FIFO storage and control
    logic [XLEN-1:0]  imm_q    [DEPTH];
    logic [2:0]       fmt_q    [DEPTH];
    logic [4:0]       rd_q     [DEPTH];
    logic             use_rd_q [DEPTH];
    logic             ill_q    [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    // flush wins over both sides of the handshake.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i]    <= '0;
                fmt_q[i]    <= '0;
                rd_q[i]     <= '0;
                use_rd_q[i] <= 1'b0;
                ill_q[i]    <= 1'b0;
                tag_q[i]    <= '0;
            end
        end else if (push) begin
            imm_q[wr_ptr]    <= dec_imm;
            fmt_q[wr_ptr]    <= dec_fmt;
            rd_q[wr_ptr]     <= dec_rd;
            use_rd_q[wr_ptr] <= dec_use_rd;
            ill_q[wr_ptr]    <= dec_illegal;
            tag_q[wr_ptr]    <= in_tag;
        end
    end

    assign out_imm     = imm_q[rd_ptr];
    assign out_fmt     = fmt_q[rd_ptr];
    assign out_rd      = rd_q[rd_ptr];
    assign out_use_rd  = use_rd_q[rd_ptr];
    assign out_illegal = ill_q[rd_ptr];
    assign out_tag     = tag_q[rd_ptr];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: a 32-bit and a 64-bit instance share all
// inputs; expected results are queued at accept and popped by per-instance
// monitors whenever the DUT hands over its head entry.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [5:0]  in_tag;
    logic        out_ready;

    logic        o32_ready, o32_valid, o32_use_rd, o32_illegal;
    logic [31:0] o32_imm;
    logic [2:0]  o32_fmt;
    logic [4:0]  o32_rd;
    logic [5:0]  o32_tag;

    logic        o64_ready, o64_valid, o64_use_rd, o64_illegal;
    logic [63:0] o64_imm;
    logic [2:0]  o64_fmt;
    logic [4:0]  o64_rd;
    logic [5:0]  o64_tag;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(6)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o32_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(o32_valid), .out_ready(out_ready), .out_imm(o32_imm),
        .out_fmt(o32_fmt), .out_rd(o32_rd), .out_use_rd(o32_use_rd),
        .out_illegal(o32_illegal), .out_tag(o32_tag)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(6)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o64_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(o64_valid), .out_ready(out_ready), .out_imm(o64_imm),
        .out_fmt(o64_fmt), .out_rd(o64_rd), .out_use_rd(o64_use_rd),
        .out_illegal(o64_illegal), .out_tag(o64_tag)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic        use_rd;
        logic        illegal;
        logic [5:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one instruction; enters and returns 1 time unit after a rising edge.
    task automatic send(input logic [31:0] inst, input logic [5:0] tag,
                        input logic [63:0] imm, input logic [2:0] fmt, input logic [4:0] rd);
        exp_t e;
        bit   done;
        int   n;
        e.imm     = imm;
        e.fmt     = fmt;
        e.rd      = rd;
        e.use_rd  = (fmt inside {3'd0, 3'd1, 3'd4, 3'd5});
        e.illegal = (fmt == 3'd7);
        e.tag     = tag;
        in_valid = 1'b1;
        in_inst  = inst;
        in_tag   = tag;
        done     = 1'b0;
        n        = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (o32_ready && !flush) begin
                q32.push_back(e);
                q64.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout tag=%0d: got no accept expected accept within 100 cycles", tag);
        end
    endtask

    // Monitor for the 32-bit instance, including head stability under stall.
    logic        held;
    logic [5:0]  held_tag;
    logic [31:0] held_imm;
    initial held = 1'b0;

    always @(negedge clk) begin
        if (!rst && held && o32_valid) begin
            check("stall_tag", 64'(o32_tag), 64'(held_tag));
            check("stall_imm", 64'(o32_imm), 64'(held_imm));
        end
        held     = !rst && !flush && o32_valid && !out_ready;
        held_tag = o32_tag;
        held_imm = o32_imm;
        if (!rst && o32_valid && out_ready) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut32_unexpected: got tag %0d expected no output", o32_tag);
            end else begin
                e32 = q32.pop_front();
                check("dut32_tag",     64'(o32_tag),     64'(e32.tag));
                check("dut32_imm",     64'(o32_imm),     64'(e32.imm[31:0]));
                check("dut32_fmt",     64'(o32_fmt),     64'(e32.fmt));
                check("dut32_rd",      64'(o32_rd),      64'(e32.rd));
                check("dut32_use_rd",  64'(o32_use_rd),  64'(e32.use_rd));
                check("dut32_illegal", 64'(o32_illegal), 64'(e32.illegal));
            end
        end
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin
        if (!rst && o64_valid && out_ready) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut64_unexpected: got tag %0d expected no output", o64_tag);
            end else begin
                e64 = q64.pop_front();
                check("dut64_tag",     64'(o64_tag),     64'(e64.tag));
                check("dut64_imm",     o64_imm,          e64.imm);
                check("dut64_fmt",     64'(o64_fmt),     64'(e64.fmt));
                check("dut64_rd",      64'(o64_rd),      64'(e64.rd));
                check("dut64_use_rd",  64'(o64_use_rd),  64'(e64.use_rd));
                check("dut64_illegal", 64'(o64_illegal), 64'(e64.illegal));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 64'(o32_valid), 64'd0);
        check("rst_in_ready",  64'(o32_ready), 64'd1);
        check("rst_imm",       64'(o32_imm),   64'd0);
        check("rst_tag",       64'(o32_tag),   64'd0);
        check("rst_fmt",       64'(o32_fmt),   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(1);

        // Streaming decode patterns with one-cycle latency.
        out_ready = 1'b1;
        send(32'hFFF00093, 6'd1, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 5'd1);
        check("latency_valid", 64'(o32_valid), 64'd1);
        send(32'hFE000EE3, 6'd2,  64'hFFFFFFFF_FFFFFFFC, 3'd3, 5'd0);
        send(32'h001000EF, 6'd3,  64'h00000000_00000800, 3'd5, 5'd1);
        send(32'h123452B7, 6'd4,  64'h00000000_12345000, 3'd4, 5'd5);
        send(32'h800002B7, 6'd5,  64'hFFFFFFFF_80000000, 3'd4, 5'd5);
        send(32'h0000007F, 6'd6,  64'h0,                 3'd7, 5'd0);
        send(32'hFFFFFFFF, 6'd7,  64'h0,                 3'd7, 5'd0);
        send(32'h002081B3, 6'd8,  64'h0,                 3'd0, 5'd3);
        send(32'hFE112E23, 6'd9,  64'hFFFFFFFF_FFFFFFFC, 3'd2, 5'd0);
        send(32'h07B00513, 6'd10, 64'h00000000_0000007B, 3'd1, 5'd10);
        send(32'h00001117, 6'd11, 64'h00000000_00001000, 3'd4, 5'd2);
        cycles(3);

        // Backpressure: two entries fill the FIFO, the third waits.
        out_ready = 1'b0;
        send(32'h00100093, 6'd20, 64'h1, 3'd1, 5'd1);
        send(32'h00200113, 6'd21, 64'h2, 3'd1, 5'd2);
        check("full_in_ready", 64'(o32_ready), 64'd0);
        fork
            send(32'h00300193, 6'd22, 64'h3, 3'd1, 5'd3);
            begin
                cycles(3);
                check("stalled_valid", 64'(o32_valid), 64'd1);
                check("stalled_head",  64'(o32_tag),   64'd20);
                out_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stream_no_gap", 64'(o32_valid), 64'd1);
                end
            end
        join
        cycles(3);

        // Flush while full, with an offer that must be dropped.
        out_ready = 1'b0;
        send(32'h00400213, 6'd30, 64'h4, 3'd1, 5'd4);
        send(32'h00500293, 6'd31, 64'h5, 3'd1, 5'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h00600313;
        in_tag   = 6'd32;
        q32.delete();
        q64.delete();
        cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid",    64'(o32_valid), 64'd0);
        check("flush_in_ready", 64'(o32_ready), 64'd1);

        // Flush with an accept while empty: accept is discarded.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h00700393;
        in_tag   = 6'd33;
        cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_drop_valid", 64'(o32_valid), 64'd0);
        out_ready = 1'b1;
        send(32'h00800413, 6'd34, 64'h8, 3'd1, 5'd8);
        cycles(3);

        // Asynchronous reset between edges while holding entries.
        out_ready = 1'b0;
        send(32'h00900493, 6'd40, 64'h9, 3'd1, 5'd9);
        send(32'hFFF00513, 6'd41, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 5'd10);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",     64'(o32_valid), 64'd0);
        check("arst_in_ready",  64'(o32_ready), 64'd1);
        check("arst_in_ready64", 64'(o64_ready), 64'd1);
        check("arst_imm32",     64'(o32_imm),   64'd0);
        check("arst_imm64",     o64_imm,        64'd0);
        check("arst_tag",       64'(o32_tag),   64'd0);
        check("arst_illegal",   64'(o32_illegal), 64'd0);
        q32.delete();
        q64.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(1);
        out_ready = 1'b1;
        send(32'hFFF00093, 6'd42, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 5'd1);
        check("post_rst_latency", 64'(o32_valid), 64'd1);

        begin
            int n;
            n = 0;
            while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
                @(posedge clk);
                n++;
            end
        end
        #1;
        check("drain_empty", 64'(q32.size() + q64.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
